// File: rtl/player_position_stepper.sv
// Per-player head stepper: moves (x,y) one grid cell per tick in the sampled direction
// and offers each cell over valid/ready. Optional macro PLAYER_WRAP_EN wraps at edges.
module player_position_stepper #(
    parameter int GRID_W   = 160,
    parameter int GRID_H   = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int START_X  = 40,
    parameter int START_Y  = 60,
    parameter int TICK_DIV = 3333333
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           go,
    input  logic [1:0]     direction,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           plot_valid,
    input  logic           plot_ready,
    output logic           crashed,
    output logic           running
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0]   X_START   = X_W'(START_X);
    localparam logic [Y_W-1:0]   Y_START   = Y_W'(START_Y);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLOT,
        S_RUN,
        S_CRASH
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    state_e           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             crashed_q, crashed_d;
    logic [CNT_W-1:0] tick_q, tick_d;

    logic             tick_done;
    logic [X_W-1:0]   step_x;
    logic [Y_W-1:0]   step_y;
    logic             step_wall;

    // Edge test precedes the add/sub so the coordinate never underflows or overflows.
    always_comb begin
        step_x    = x_q;
        step_y    = y_q;
        step_wall = 1'b0;
        case (dir_e'(direction))
            DIR_UP: begin
                if (y_q == '0) begin
`ifdef PLAYER_WRAP_EN
                    step_y = Y_MAX;
`else
                    step_wall = 1'b1;
`endif
                end else begin
                    step_y = y_q - Y_W'(1);
                end
            end
            DIR_DOWN: begin
                if (y_q == Y_MAX) begin
`ifdef PLAYER_WRAP_EN
                    step_y = '0;
`else
                    step_wall = 1'b1;
`endif
                end else begin
                    step_y = y_q + Y_W'(1);
                end
            end
            DIR_LEFT: begin
                if (x_q == '0) begin
`ifdef PLAYER_WRAP_EN
                    step_x = X_MAX;
`else
                    step_wall = 1'b1;
`endif
                end else begin
                    step_x = x_q - X_W'(1);
                end
            end
            default: begin
                if (x_q == X_MAX) begin
`ifdef PLAYER_WRAP_EN
                    step_x = '0;
`else
                    step_wall = 1'b1;
`endif
                end else begin
                    step_x = x_q + X_W'(1);
                end
            end
        endcase
    end

    // Tick counter only advances in RUN; any other state (and entry to RUN) sees it at 0.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        crashed_d = crashed_q;
        tick_d    = '0;
        tick_done = (tick_q == TICK_LAST);
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_PLOT;
                end
            end
            S_PLOT: begin
                if (plot_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (tick_done) begin
                    if (step_wall) begin
                        crashed_d = 1'b1;
                        state_d   = S_CRASH;
                    end else begin
                        x_d     = step_x;
                        y_d     = step_y;
                        state_d = S_PLOT;
                    end
                end else begin
                    tick_d = tick_q + CNT_W'(1);
                end
            end
            S_CRASH: begin
                state_d = S_CRASH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            x_q       <= X_START;
            y_q       <= Y_START;
            crashed_q <= 1'b0;
            tick_q    <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            crashed_q <= crashed_d;
            tick_q    <= tick_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign plot_valid = (state_q == S_PLOT);
    assign running    = (state_q == S_RUN);
    assign crashed    = crashed_q;

endmodule

// File: tb/tb_player_position_stepper.sv
// Directed bench for player_position_stepper: a mid-grid instance for stepping, stalls
// and reset, and a near-top-edge instance for the crash (or wrap) case.
module tb_player_position_stepper;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn_a, go_a, ready_a, pv_a, crashed_a, running_a;
    logic [1:0] dir_a;
    logic [7:0] x_a;
    logic [6:0] y_a;

    logic       resetn_b, go_b, ready_b, pv_b, crashed_b, running_b;
    logic [1:0] dir_b;
    logic [7:0] x_b;
    logic [6:0] y_b;

    int n_checks = 0;
    int n_fail   = 0;

    player_position_stepper #(
        .GRID_W(160), .GRID_H(120), .X_W(8), .Y_W(7),
        .START_X(40), .START_Y(60), .TICK_DIV(TICK_DIV)
    ) u_dut (
        .clk(clk), .resetn(resetn_a), .go(go_a), .direction(dir_a),
        .x_out(x_a), .y_out(y_a), .plot_valid(pv_a), .plot_ready(ready_a),
        .crashed(crashed_a), .running(running_a)
    );

    player_position_stepper #(
        .GRID_W(160), .GRID_H(120), .X_W(8), .Y_W(7),
        .START_X(40), .START_Y(1), .TICK_DIV(TICK_DIV)
    ) u_dut_edge (
        .clk(clk), .resetn(resetn_b), .go(go_b), .direction(dir_b),
        .x_out(x_b), .y_out(y_b), .plot_valid(pv_b), .plot_ready(ready_b),
        .crashed(crashed_b), .running(running_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered just after RUN begins; direction is a decoy until the terminal tick.
    task automatic step_a(input logic [1:0] dir, input int ex, input int ey, input string tag);
        int n;
        n = 0;
        dir_a = ~dir;
        while (!pv_a && n < 20) begin
            if (n == 3) dir_a = dir;
            cyc();
            n++;
        end
        check_eq({tag, "_lat"}, n, 4);
        check_eq({tag, "_x"}, x_a, ex);
        check_eq({tag, "_y"}, y_a, ey);
        cyc();
        check_eq({tag, "_run"}, {pv_a, running_a}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        resetn_a = 1'b0; go_a = 1'b0; ready_a = 1'b0; dir_a = 2'b01;
        resetn_b = 1'b0; go_b = 1'b0; ready_b = 1'b0; dir_b = 2'b00;
        cyc();
        cyc();

        check_eq("rst_pv", pv_a, 0);
        check_eq("rst_x", x_a, 40);
        check_eq("rst_y", y_a, 60);
        check_eq("rst_crashed", crashed_a, 0);
        check_eq("rst_running", running_a, 0);

        resetn_a = 1'b1;
        go_a = 1'b1;
        cyc();
        go_a = 1'b0;
        check_eq("start_pv", pv_a, 1);
        check_eq("start_xy", {x_a, y_a}, {8'd40, 7'd60});
        check_eq("start_running", running_a, 0);

        for (int i = 0; i < 10; i++) begin
            cyc();
            check_eq("stall_pv", pv_a, 1);
            check_eq("stall_xy", {x_a, y_a}, {8'd40, 7'd60});
        end

        ready_a = 1'b1;
        cyc();
        check_eq("accept_run", {pv_a, running_a}, 2'b01);

        step_a(2'b01, 41, 60, "right1");
        step_a(2'b01, 42, 60, "right2");
        step_a(2'b01, 43, 60, "right3");
        step_a(2'b11, 43, 61, "down");
        step_a(2'b10, 42, 61, "left");
        step_a(2'b00, 42, 60, "up");

        // Stall a plot, poke go (ignored), then reset mid-handshake.
        ready_a = 1'b0;
        dir_a = 2'b01;
        n = 0;
        while (!pv_a && n < 20) begin
            cyc();
            n++;
        end
        check_eq("pre_rst_pv", pv_a, 1);
        go_a = 1'b1;
        repeat (3) cyc();
        check_eq("go_in_plot_pv", pv_a, 1);
        check_eq("go_in_plot_xy", {x_a, y_a}, {8'd43, 7'd60});
        resetn_a = 1'b0;
        cyc();
        check_eq("midrst_pv", pv_a, 0);
        check_eq("midrst_xy", {x_a, y_a}, {8'd40, 7'd60});
        check_eq("midrst_running", running_a, 0);
        resetn_a = 1'b1;
        go_a = 1'b0;
        cyc();
        check_eq("idle_hold", {pv_a, running_a}, 2'b00);

        // Edge instance: step UP from y=1 to y=0, then into the wall.
        resetn_b = 1'b1;
        go_b = 1'b1;
        ready_b = 1'b1;
        cyc();
        go_b = 1'b0;
        check_eq("edge_start", {pv_b, x_b, y_b}, {1'b1, 8'd40, 7'd1});
        cyc();
        check_eq("edge_run", running_b, 1);
        n = 0;
        while (!pv_b && n < 20) begin
            cyc();
            n++;
        end
        check_eq("edge_top_lat", n, 4);
        check_eq("edge_top_xy", {x_b, y_b}, {8'd40, 7'd0});
        cyc();
        n = 0;
        while (!pv_b && !crashed_b && n < 20) begin
            cyc();
            n++;
        end
        check_eq("edge_wall_lat", n, 4);
`ifdef PLAYER_WRAP_EN
        check_eq("wrap_pv", pv_b, 1);
        check_eq("wrap_xy", {x_b, y_b}, {8'd40, 7'd119});
        check_eq("wrap_crashed", crashed_b, 0);
`else
        check_eq("crash_flag", crashed_b, 1);
        check_eq("crash_pv_run", {pv_b, running_b}, 2'b00);
        check_eq("crash_xy", {x_b, y_b}, {8'd40, 7'd0});
        go_b = 1'b1;
        repeat (3) cyc();
        go_b = 1'b0;
        check_eq("crash_go_ignored", {crashed_b, pv_b, running_b}, 3'b100);
        check_eq("crash_xy_frozen", {x_b, y_b}, {8'd40, 7'd0});
`endif
        resetn_b = 1'b0;
        cyc();
        check_eq("edge_rst", {crashed_b, pv_b, y_b}, {1'b0, 1'b0, 7'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
